// File: rtl/tempsens_host_reader.sv
`default_nettype none
// ============================================================================
// Module   : tempsens_host_reader
// Purpose  : Host side of the temperature-sensor UART link. On start it sends
//            one command byte (8N1), receives a two-byte response (low, high)
//            and presents the 16-bit result with a one-cycle valid strobe.
//            Timeout and framing errors are reported as one-cycle pulses.
// Revision : 1.0  initial release
// ============================================================================
module tempsens_host_reader #(
   parameter int         CLK_FREQ = 10000,
   parameter int         BAUD     = 1000,
   parameter logic [7:0] CMD      = 8'h01,
   parameter int         TIMEOUT  = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx,
   output logic        tx,
   output logic        busy,
   output logic [15:0] result,
   output logic        result_valid,
   output logic        timeout_err,
   output logic        frame_err
);

   localparam int BIT_CYC  = CLK_FREQ / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CW       = $clog2(BIT_CYC + 1);
   localparam int TW       = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_CYC - 1);
   localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [9:0]    C_FRAME     = {1'b1, CMD, 1'b0};

   // Completion is folded into the WAIT_HI exit so that result_valid rises
   // in the same cycle busy falls.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND    = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3
   } state_t;

   typedef enum logic [1:0] {
      R_HUNT  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

   state_t    state, state_next;
   rx_state_t rx_phase;

   logic          rx_s1, rx_s2, rx_s3;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;
   logic [TW-1:0] to_cnt;
   logic [7:0]    lo_byte;

   logic rx_en, rx_fall, stop_tick, byte_ok, byte_bad, tx_last, timeout_hit;
   logic valid_next, to_next, fe_next;

   assign rx_en       = (state == S_WAIT_LO) || (state == S_WAIT_HI);
   assign rx_fall     = rx_s3 & ~rx_s2;
   assign stop_tick   = (rx_phase == R_STOP) && (rx_cnt == C_BIT_LAST);
   assign byte_ok     = stop_tick & rx_s2;
   assign byte_bad    = stop_tick & ~rx_s2;
   assign tx_last     = (state == S_SEND) && (tx_cnt == C_BIT_LAST) && (tx_idx == 4'd9);
   // A start edge seen in the same cycle as expiry takes precedence.
   assign timeout_hit = (rx_phase == R_HUNT) && !rx_fall && (to_cnt == C_TO_LAST);

   assign busy = (state != S_IDLE);
   assign tx   = (state == S_SEND) ? C_FRAME[tx_idx] : 1'b1;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic and pulse requests for the registered strobes.
   always_comb begin
      state_next = state;
      valid_next = 1'b0;
      to_next    = 1'b0;
      fe_next    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_SEND;
         end
         S_SEND: begin
            if (tx_last) state_next = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (byte_bad) begin
               fe_next    = 1'b1;
               state_next = S_IDLE;
            end else if (byte_ok) begin
               state_next = S_WAIT_HI;
            end else if (timeout_hit) begin
               to_next    = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_WAIT_HI: begin
            if (byte_bad) begin
               fe_next    = 1'b1;
               state_next = S_IDLE;
            end else if (byte_ok) begin
               valid_next = 1'b1;
               state_next = S_IDLE;
            end else if (timeout_hit) begin
               to_next    = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output strobes, low-byte holding register and the result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
         frame_err    <= 1'b0;
         result       <= 16'h0000;
         lo_byte      <= 8'h00;
      end else begin
         result_valid <= valid_next;
         timeout_err  <= to_next;
         frame_err    <= fe_next;
         if (state == S_WAIT_LO && byte_ok) lo_byte <= rx_shift;
         if (valid_next)                    result  <= {rx_shift, lo_byte};
      end
   end

   // Command transmitter bit-period and bit-index counters.
   always_ff @(posedge clk) begin
      if (reset || state != S_SEND) begin
         tx_cnt <= '0;
         tx_idx <= 4'd0;
      end else if (tx_cnt == C_BIT_LAST) begin
         tx_cnt <= '0;
         tx_idx <= tx_idx + 4'd1;
      end else begin
         tx_cnt <= tx_cnt + CW'(1);
      end
   end

   // Response timeout counter: runs only while hunting for a start bit.
   always_ff @(posedge clk) begin
      if (reset || !rx_en || state_next != state) begin
         to_cnt <= '0;
      end else if (rx_phase != R_HUNT || rx_fall) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // Input synchronizer plus one extra stage for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   // Receiver: mid-start check, 8 data samples, stop sample at bit spacing.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_phase <= R_HUNT;
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
      end else if (!rx_en) begin
         rx_phase <= R_HUNT;
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
      end else begin
         case (rx_phase)
            R_HUNT: begin
               // The detect cycle already counts as one cycle past the edge.
               if (rx_fall) begin
                  rx_phase <= R_START;
                  rx_cnt   <= CW'(1);
               end
            end
            R_START: begin
               if (rx_cnt == C_HALF_LAST) begin
                  rx_phase <= rx_s2 ? R_HUNT : R_DATA;
                  rx_cnt   <= '0;
                  rx_bit   <= 3'd0;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            R_DATA: begin
               if (rx_cnt == C_BIT_LAST) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= '0;
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_phase <= R_STOP;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            default: begin
               if (rx_cnt == C_BIT_LAST) begin
                  rx_phase <= R_HUNT;
                  rx_cnt   <= '0;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tempsens_host_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tempsens_host_reader
// Purpose  : Self-checking bench for tempsens_host_reader with a simple
//            bit-banged UART reply model and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_tempsens_host_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rx = 1'b1;
   logic        tx, busy, result_valid, timeout_err, frame_err;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0, n_to = 0, n_fe = 0, n_txlow = 0;
   int valid_cyc = 0, to_cyc = 0;

   typedef struct {
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[4];

   tempsens_host_reader #(
      .CLK_FREQ(10000),
      .BAUD    (1000),
      .CMD     (8'h01),
      .TIMEOUT (2000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .rx          (rx),
      .tx          (tx),
      .busy        (busy),
      .result      (result),
      .result_valid(result_valid),
      .timeout_err (timeout_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   // Posedge counter used to time pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse and tx-low monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (result_valid) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
      end
      if (timeout_err) begin
         n_to   <= n_to + 1;
         to_cyc <= cyc;
      end
      if (frame_err) n_fe <= n_fe + 1;
      if (!tx) n_txlow <= n_txlow + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (10) tick();
      end
      rx = stop_bit;
      repeat (10) tick();
      rx = 1'b1;
   endtask

   // Full transaction: start, check command frame, reply lo/hi, check result.
   task automatic do_read(input logic [7:0] lo, input logic [7:0] hi,
                          input logic [15:0] exp, output int c_hi);
      logic [9:0] fr;
      int bad, v0, e0;
      fr  = {1'b1, 8'h01, 1'b0};
      bad = 0;
      v0  = n_valid;
      e0  = n_to + n_fe;
      pulse_start();
      chk("busy_at_start", busy, 1);
      for (int i = 0; i < 100; i++) begin
         if (tx !== fr[i/10]) bad++;
         tick();
      end
      chk("tx_frame_bits", bad, 0);
      send_byte(lo, 1'b1);
      c_hi = cyc;
      send_byte(hi, 1'b1);
      repeat (3) tick();
      chk("read_result", result, exp);
      chk("valid_pulses", n_valid - v0, 1);
      chk("busy_after_read", busy, 0);
      chk("no_err_pulses", (n_to + n_fe) - e0, 0);
   endtask

   initial begin
      int c_hi, v0, f0, t0, l0, s;
      logic [15:0] r0;

      vecs[0] = '{lo: 8'h01, hi: 8'h00, exp: 16'h0001};
      vecs[1] = '{lo: 8'hA5, hi: 8'h5A, exp: 16'h5AA5};
      vecs[2] = '{lo: 8'h00, hi: 8'h80, exp: 16'h8000};
      vecs[3] = '{lo: 8'h7E, hi: 8'h3C, exp: 16'h3C7E};

      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_result", result, 16'h0000);
      chk("reset_valid", result_valid, 0);
      chk("reset_timeout", timeout_err, 0);
      chk("reset_frame", frame_err, 0);

      // Nominal read with latency check: first sync low 2 cycles after the
      // hi start bit, stop sample 95 cycles later, strobe visible after it.
      do_read(8'h34, 8'h12, 16'h1234, c_hi);
      chk("valid_latency", valid_cyc - c_hi, 97);

      for (int k = 0; k < 4; k++) begin
         do_read(vecs[k].lo, vecs[k].hi, vecs[k].exp, c_hi);
      end

      // Framing error: stop bit low on the first reply byte.
      r0 = result;
      v0 = n_valid;
      f0 = n_fe;
      pulse_start();
      repeat (100) tick();
      send_byte(8'hAA, 1'b0);
      repeat (5) tick();
      chk("frame_err_pulses", n_fe - f0, 1);
      chk("frame_no_valid", n_valid - v0, 0);
      chk("frame_result_kept", result, r0);
      chk("frame_busy", busy, 0);
      do_read(8'h01, 8'h00, 16'h0001, c_hi);

      // Glitch rejection: 3-cycle low pulse, then a valid reply.
      v0 = n_valid;
      f0 = n_fe + n_to;
      pulse_start();
      repeat (100) tick();
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (20) tick();
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      repeat (3) tick();
      chk("glitch_result", result, 16'hFFFF);
      chk("glitch_valid", n_valid - v0, 1);
      chk("glitch_no_err", (n_fe + n_to) - f0, 0);

      // Second start during SEND is ignored: exactly 80 tx-low cycles.
      l0 = n_txlow;
      v0 = n_valid;
      pulse_start();
      repeat (30) tick();
      pulse_start();
      repeat (69) tick();
      repeat (200) tick();
      chk("single_cmd_txlow", n_txlow - l0, 80);
      chk("busy_waiting", busy, 1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      repeat (3) tick();
      chk("retrigger_result", result, 16'h1234);
      chk("retrigger_valid", n_valid - v0, 1);

      // No response: timeout 2000 cycles after WAIT_LO entry.
      r0 = result;
      t0 = n_to;
      v0 = n_valid;
      s  = cyc;
      pulse_start();
      repeat (2200) tick();
      chk("timeout_pulses", n_to - t0, 1);
      chk("timeout_timing", to_cyc - s, 2101);
      chk("timeout_result_kept", result, r0);
      chk("timeout_no_valid", n_valid - v0, 0);
      chk("timeout_busy", busy, 0);

      // Reset mid-command.
      pulse_start();
      repeat (25) tick();
      chk("busy_before_reset", busy, 1);
      reset = 1'b1;
      tick();
      chk("midreset_tx", tx, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_result", result, 16'h0000);
      reset = 1'b0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
